rl_ref_force_accumulator: RTL
=============================

Name: rl_ref_force_accumulator

Overview:
- Sits directly downstream of the range-limited force evaluation unit and consumes its per-pair force stream: ref particle id, neighbour id, Fx/Fy/Fz (IEEE-754 single) and valid.
- Sums per-pair forces into one total force per reference particle and emits it when the reference id changes or on an explicit flush.
- In parallel, emits the negated per-pair force (Newton's third law) tagged with the neighbour id, for the neighbour-force cache.

Parameters:
DATA_WIDTH, 32, float width (IEEE single only)
CELL_ID_WIDTH, 3, per-axis cell id width
PARTICLE_ID_WIDTH, 7, particle id width within a cell
ID_WIDTH, 3*CELL_ID_WIDTH+PARTICLE_ID_WIDTH, full neighbour id width
CNT_WIDTH, 8, accumulated-pair counter width (saturating)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
in_ref_id  in  PARTICLE_ID_WIDTH  reference particle id of the pair
in_nb_id  in  ID_WIDTH  neighbour full id of the pair
in_force_x/y/z  in  DATA_WIDTH each  pair force on the reference particle
in_valid  in  1  pair force valid
flush  in  1  one-cycle pulse from the pair-generation FSM at the end of a home cell
out_ref_id  out  PARTICLE_ID_WIDTH  id of the completed reference particle
out_ref_force_x/y/z  out  DATA_WIDTH each  accumulated force
out_ref_pair_cnt  out  CNT_WIDTH  number of pairs summed
out_ref_valid  out  1  one-cycle pulse
out_nb_id  out  ID_WIDTH  neighbour id
out_nb_force_x/y/z  out  DATA_WIDTH each  negated pair force
out_nb_valid  out  1  neighbour force valid
busy  out  1  high in ACCUM state

Behaviour:
- Reset: all outputs, accumulators, current-id register and counter go to 0; FSM goes to IDLE. A reset mid-accumulation discards the partial sum without emitting it.
- FSM states: IDLE (no open ref) and ACCUM (cur_id open).
- IDLE + in_valid: cur_id <= in_ref_id; acc <= in_force; cnt <= 1; go to ACCUM.
- ACCUM + in_valid + (in_ref_id == cur_id): acc <= acc + in_force (per axis, combinational fp add, registered); cnt <= cnt+1, saturating at 2^CNT_WIDTH-1.
- ACCUM + in_valid + (in_ref_id != cur_id): emit {cur_id, acc, cnt} next cycle with out_ref_valid=1; acc <= in_force; cnt <= 1; cur_id <= in_ref_id; stay in ACCUM. No sample is lost.
- ACCUM + flush, no in_valid: emit {cur_id, acc, cnt}; go to IDLE.
- ACCUM + flush + in_valid with the same id: the sample is added first, the sum including it is emitted, then go to IDLE.
- ACCUM + flush + in_valid with a different id: emit the old particle; the new sample opens ACCUM for in_ref_id (the flush applies to the old particle only).
- IDLE + flush: ignored; no output.
- Ref-output latency: out_ref_valid asserts exactly 1 cycle after the triggering edge (id change or flush). Output data holds until the next emission; out_ref_valid is a one-cycle pulse.
- Neighbour path: out_nb_* is registered with latency 1 cycle from in_valid. Each force has sign bit [DATA_WIDTH-1] inverted; all other bits pass through unchanged (so -0 and +0 flip, NaN passes with its sign flipped). out_nb_valid = in_valid delayed 1 cycle. This path is independent of the FSM.
- Adder rules: round-to-nearest-even. Denormals are flushed to zero. +0 + -0 = +0.
- No back-pressure: the block accepts one pair per cycle unconditionally.

Decomposition:
- Shared package md_force_pkg holds:
  - typedef float_t (DATA_WIDTH bits)
  - struct force3_t {x, y, z}
  - constant FP_SIGN_BIT
  - acc_state_e {IDLE, ACCUM}
- One sub-module, fp32_add_comb: combinational single-precision adder, instanced three times (x, y, z).

Test Plan:
1. Ref 5, three pairs with Fx = 0x3F800000 (1.0), then flush -> out_ref_valid 1 cycle later: id 5, Fx 0x40400000 (3.0), cnt 3; FSM in IDLE.
2. Ref 5 sends 2 pairs of 1.0 each, then ref 6 sends 1 pair of 2.0, then flush -> two out_ref_valid pulses: (5, 0x40000000, cnt 2) and (6, 0x40000000, cnt 1). No sample is dropped.
3. Pair with in_nb_id 0x1A3, Fy 0x3F800000 -> next cycle out_nb_valid=1, out_nb_id 0x1A3, out_nb_force_y 0xBF800000. Fz=0x00000000 -> 0x80000000.
4. Flush with in_valid on the same cycle, same id (ref 2: two pairs of 1.0, the last one arriving with flush) -> emit (2, 2.0, cnt 2). Repeat with a different id -> emit the old particle, then the new one stays open.
5. Assert rst while in ACCUM with a partial sum -> no out_ref_valid. All outputs 0 on the next cycle. A following single pair of 1.0 plus flush -> emit 1.0, cnt 1.
6. Send 300 pairs of 0x00000000 for one ref, then flush -> cnt saturates at 255, force 0x00000000.

Source files
------------

// File: rtl/md_force_pkg.sv
// Shared types for the range-limited force pipeline: float word, 3-axis force and the
// accumulator FSM states.
package md_force_pkg;

    localparam int FP_WIDTH    = 32;
    localparam int FP_SIGN_BIT = FP_WIDTH - 1;

    typedef logic [FP_WIDTH-1:0] float_t;

    typedef struct packed {
        float_t x;
        float_t y;
        float_t z;
    } force3_t;

    typedef enum logic [0:0] {
        IDLE,
        ACCUM
    } acc_state_e;

endpackage

// File: rtl/fp32_add_comb.sv
// Combinational IEEE-754 single-precision adder.
// Round-to-nearest-even, denormal inputs and results flushed to zero, +0 + -0 = +0.
module fp32_add_comb
    import md_force_pkg::*;
(
    input  float_t a,
    input  float_t b,
    output float_t sum
);

    localparam float_t QNAN = 32'h7FC0_0000;

    logic               sa, sb, sl, ss;
    logic [7:0]         ea, eb, el, es, diff;
    logic [23:0]        ma, mb, ml, ms;
    logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, swap;
    logic [26:0]        mx, my, ms_full, m_norm;
    logic [27:0]        m_sum;
    logic [4:0]         lz;
    logic               found, round_up;
    logic [24:0]        m_rnd;
    logic [22:0]        frac;
    logic signed [9:0]  exp_r;

    // Align, add/subtract, normalise, round, then pick special-case results.
    always_comb begin
        sa     = a[31];
        sb     = b[31];
        ea     = a[30:23];
        eb     = b[30:23];
        ma     = {1'b1, a[22:0]};
        mb     = {1'b1, b[22:0]};
        a_zero = (ea == 8'h00);
        b_zero = (eb == 8'h00);
        a_inf  = (ea == 8'hFF) && (a[22:0] == 23'd0);
        b_inf  = (eb == 8'hFF) && (b[22:0] == 23'd0);
        a_nan  = (ea == 8'hFF) && (a[22:0] != 23'd0);
        b_nan  = (eb == 8'hFF) && (b[22:0] != 23'd0);

        // Larger magnitude operand goes first so the subtraction never goes negative
        swap = {eb, b[22:0]} > {ea, a[22:0]};
        sl   = swap ? sb : sa;
        ss   = swap ? sa : sb;
        el   = swap ? eb : ea;
        es   = swap ? ea : eb;
        ml   = swap ? mb : ma;
        ms   = swap ? ma : mb;
        diff = el - es;

        // Three extra bits: guard, round, sticky
        mx      = {ml, 3'b000};
        ms_full = {ms, 3'b000};
        if (diff >= 8'd27) begin
            my = 27'd1;
        end else begin
            my    = ms_full >> diff;
            my[0] = my[0] | (|(ms_full & ~({27{1'b1}} << diff)));
        end

        if (sl == ss) m_sum = {1'b0, mx} + {1'b0, my};
        else          m_sum = {1'b0, mx} - {1'b0, my};

        exp_r = signed'({2'b00, el});
        lz    = 5'd0;
        found = 1'b0;
        if (m_sum[27]) begin
            m_norm = {m_sum[27:2], m_sum[1] | m_sum[0]};
            exp_r  = exp_r + 10'sd1;
        end else begin
            for (int i = 26; i >= 0; i--) begin
                if (!found && m_sum[i]) begin
                    lz    = 5'(26 - i);
                    found = 1'b1;
                end
            end
            m_norm = m_sum[26:0] << lz;
            exp_r  = exp_r - signed'({5'b00000, lz});
        end

        round_up = m_norm[2] & (m_norm[1] | m_norm[0] | m_norm[3]);
        m_rnd    = {1'b0, m_norm[26:3]} + {24'd0, round_up};
        if (m_rnd[24]) begin
            exp_r = exp_r + 10'sd1;
            frac  = m_rnd[23:1];
        end else begin
            frac  = m_rnd[22:0];
        end

        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) sum = QNAN;
        else if (a_inf)                                       sum = a;
        else if (b_inf)                                       sum = b;
        else if (a_zero && b_zero)                            sum = {sa & sb, 31'd0};
        else if (a_zero)                                      sum = b;
        else if (b_zero)                                      sum = a;
        else if (m_sum == 28'd0)                              sum = 32'd0;
        else if (exp_r >= 10'sd255)                           sum = {sl, 8'hFF, 23'd0};
        else if (exp_r <= 10'sd0)                             sum = {sl, 31'd0};
        else                                                  sum = {sl, exp_r[7:0], frac};
    end

endmodule

// File: rtl/rl_ref_force_accumulator.sv
// Sums per-pair forces into one total per reference particle and, in parallel, forwards the
// negated pair force tagged with the neighbour id for the neighbour-force cache.
module rl_ref_force_accumulator
    import md_force_pkg::*;
#(
    parameter int DATA_WIDTH        = 32,
    parameter int CELL_ID_WIDTH     = 3,
    parameter int PARTICLE_ID_WIDTH = 7,
    parameter int ID_WIDTH          = 3 * CELL_ID_WIDTH + PARTICLE_ID_WIDTH,
    parameter int CNT_WIDTH         = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [PARTICLE_ID_WIDTH-1:0] in_ref_id,
    input  logic [ID_WIDTH-1:0]          in_nb_id,
    input  logic [DATA_WIDTH-1:0]        in_force_x,
    input  logic [DATA_WIDTH-1:0]        in_force_y,
    input  logic [DATA_WIDTH-1:0]        in_force_z,
    input  logic                         in_valid,
    input  logic                         flush,
    output logic [PARTICLE_ID_WIDTH-1:0] out_ref_id,
    output logic [DATA_WIDTH-1:0]        out_ref_force_x,
    output logic [DATA_WIDTH-1:0]        out_ref_force_y,
    output logic [DATA_WIDTH-1:0]        out_ref_force_z,
    output logic [CNT_WIDTH-1:0]         out_ref_pair_cnt,
    output logic                         out_ref_valid,
    output logic [ID_WIDTH-1:0]          out_nb_id,
    output logic [DATA_WIDTH-1:0]        out_nb_force_x,
    output logic [DATA_WIDTH-1:0]        out_nb_force_y,
    output logic [DATA_WIDTH-1:0]        out_nb_force_z,
    output logic                         out_nb_valid,
    output logic                         busy
);

    acc_state_e                   state_q, state_d;
    logic [PARTICLE_ID_WIDTH-1:0] cur_id_q, cur_id_d, emit_id;
    force3_t                      acc_q, acc_d, in_force, sum_f, emit_force;
    logic [CNT_WIDTH-1:0]         cnt_q, cnt_d, cnt_inc, emit_cnt;
    float_t                       sum_x, sum_y, sum_z;
    logic                         emit;

    assign in_force = {in_force_x, in_force_y, in_force_z};
    assign sum_f    = {sum_x, sum_y, sum_z};
    assign cnt_inc  = (cnt_q == {CNT_WIDTH{1'b1}}) ? cnt_q : cnt_q + CNT_WIDTH'(1);
    assign busy     = (state_q == ACCUM);

    fp32_add_comb u_add_x (.a(acc_q.x), .b(in_force.x), .sum(sum_x));
    fp32_add_comb u_add_y (.a(acc_q.y), .b(in_force.y), .sum(sum_y));
    fp32_add_comb u_add_z (.a(acc_q.z), .b(in_force.z), .sum(sum_z));

    // Next-state: open, extend, hand over or close the current reference particle.
    always_comb begin
        state_d    = state_q;
        cur_id_d   = cur_id_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        emit       = 1'b0;
        emit_id    = cur_id_q;
        emit_force = acc_q;
        emit_cnt   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    cur_id_d = in_ref_id;
                    acc_d    = in_force;
                    cnt_d    = CNT_WIDTH'(1);
                    state_d  = ACCUM;
                end
            end
            ACCUM: begin
                if (in_valid && (in_ref_id == cur_id_q)) begin
                    acc_d = sum_f;
                    cnt_d = cnt_inc;
                    // Same-id sample arriving with flush is included in the emitted sum
                    if (flush) begin
                        emit       = 1'b1;
                        emit_force = sum_f;
                        emit_cnt   = cnt_inc;
                        acc_d      = '0;
                        cnt_d      = '0;
                        state_d    = IDLE;
                    end
                end else if (in_valid) begin
                    // New id closes the old particle; a coincident flush is absorbed here
                    emit     = 1'b1;
                    cur_id_d = in_ref_id;
                    acc_d    = in_force;
                    cnt_d    = CNT_WIDTH'(1);
                end else if (flush) begin
                    emit    = 1'b1;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Accumulator state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cur_id_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            cur_id_q <= cur_id_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    // Reference output: one-cycle valid pulse, data held until the next emission.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_ref_valid    <= 1'b0;
            out_ref_id       <= '0;
            out_ref_force_x  <= '0;
            out_ref_force_y  <= '0;
            out_ref_force_z  <= '0;
            out_ref_pair_cnt <= '0;
        end else begin
            out_ref_valid <= emit;
            if (emit) begin
                out_ref_id       <= emit_id;
                out_ref_force_x  <= emit_force.x;
                out_ref_force_y  <= emit_force.y;
                out_ref_force_z  <= emit_force.z;
                out_ref_pair_cnt <= emit_cnt;
            end
        end
    end

    // Neighbour path: sign-flipped pair force, independent of the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_nb_valid   <= 1'b0;
            out_nb_id      <= '0;
            out_nb_force_x <= '0;
            out_nb_force_y <= '0;
            out_nb_force_z <= '0;
        end else begin
            out_nb_valid   <= in_valid;
            out_nb_id      <= in_nb_id;
            out_nb_force_x <= in_force_x ^ (DATA_WIDTH'(1) << FP_SIGN_BIT);
            out_nb_force_y <= in_force_y ^ (DATA_WIDTH'(1) << FP_SIGN_BIT);
            out_nb_force_z <= in_force_z ^ (DATA_WIDTH'(1) << FP_SIGN_BIT);
        end
    end

endmodule
